droop_detector: RTL and testbench
=================================

Name: droop_detector

Overview:
- Supply-droop detector that generates the `brake` request consumed by the PLL's droop manager. It sits directly upstream of that manager.
- Input is a stream of supply-monitor codes from the on-die ring-oscillator supply sensor, sampled in the refclk domain. Higher code means higher VDD.
- The block learns a baseline, tracks slow drift, and asserts brake on a qualified fast drop below baseline. Release uses hysteresis plus a minimum hold time.

Parameters:
- W, 10: sense_code and baseline width (bits).
- CAL_LOG2, 4: calibration averages 2^CAL_LOG2 valid samples.
- TRACK_SHIFT, 6: IIR baseline tracking shift while ARMED.
- TRIP_DELTA, 24: slow-trip margin below baseline (codes).
- TRIP_COUNT, 3: consecutive valid samples below the slow-trip threshold needed to trip.
- FAST_DELTA, 64: single-sample fast-trip margin (codes).
- RELEASE_DELTA, 8: release margin below baseline (codes); must be < TRIP_DELTA.
- RELEASE_COUNT, 16: consecutive valid samples above the release threshold needed to release.
- MIN_HOLD, 64: minimum refclk cycles brake stays asserted.

Ports:
- refclk  in  1  reference clock.
- resetn  in  1  reset, asynchronous, active-low.
- enable  in  1  detector enable; synchronous to refclk.
- sense_valid  in  1  sense_code valid this cycle.
- sense_code  in  W  supply-monitor code, unsigned.
- clear_seen  in  1  synchronous clear of droop_seen.
- brake  out  1  droop request to the droop manager; registered.
- det_state  out  2  droop_det_state_t, current FSM state.
- baseline  out  W  current baseline code.
- droop_events  out  16  count of trips; saturates at 16'hFFFF.
- droop_seen  out  1  sticky; set on any trip.

Behaviour:
- Reset values: brake=0, det_state=IDLE, baseline=0, droop_events=0, droop_seen=0. All internal counters and accumulators are 0.
- Thresholds are combinational from baseline, computed unsigned and clamped at 0:
  - trip_th = max(baseline-TRIP_DELTA, 0)
  - fast_th = max(baseline-FAST_DELTA, 0)
  - rel_th = max(baseline-RELEASE_DELTA, 0)
- "Below" means strictly less than the threshold; a code equal to a threshold is not below. A threshold of 0 can never be crossed.
- Only cycles with sense_valid=1 advance sample counters. Hold counting uses refclk cycles regardless of sense_valid.
- IDLE:
  - brake=0.
  - enable=1 -> go to CAL and clear the calibration sum and count.
- CAL:
  - On each valid sample, accumulate into a (W+CAL_LOG2)-bit sum.
  - On the 2^CAL_LOG2-th sample: baseline <= sum>>CAL_LOG2, track accumulator <= that value<<TRACK_SHIFT, go to ARMED.
  - No trips are possible in CAL.
- ARMED:
  - For each valid sample that is not below trip_th: track_acc <= track_acc + code - (track_acc>>TRACK_SHIFT), with baseline = track_acc>>TRACK_SHIFT. The accumulator is W+TRACK_SHIFT bits and cannot overflow.
  - For samples below trip_th, the baseline is frozen and slow_cnt increments.
  - Any valid sample that is not below trip_th resets slow_cnt to 0.
  - Trip condition: a valid sample below fast_th, OR slow_cnt reaches TRIP_COUNT (the TRIP_COUNT-th consecutive below sample).
  - On trip: go to TRIPPED, brake=1 in the next cycle (1-cycle latency from the qualifying sample), droop_events += 1 (saturating), droop_seen=1, hold_cnt=MIN_HOLD, rel_cnt=0.
- TRIPPED:
  - Baseline is frozen; brake=1.
  - hold_cnt decrements each refclk cycle down to 0.
  - A valid sample at or above rel_th increments rel_cnt. A valid sample below rel_th clears rel_cnt.
  - Exit when hold_cnt==0 and rel_cnt>=RELEASE_COUNT: go to ARMED, brake=0 next cycle, slow_cnt=0.
  - rel_cnt saturates at RELEASE_COUNT. Samples may qualify while the hold is still running.
- enable=0 in any state:
  - Go to IDLE next cycle and force brake=0.
  - Baseline, droop_events and droop_seen are retained.
  - Re-enabling always recalibrates.
- Simultaneous events:
  - clear_seen in the same cycle as a trip leaves droop_seen=1 (set wins).
  - A fast and slow trip in the same cycle count as one event.
- Asynchronous reset mid-droop drops brake immediately. The downstream droop manager then sees brake=0.

Decomposition:
- Shared package droop_pkg:
  - droop_det_state_t {IDLE, CAL, ARMED, TRIPPED}, 2-bit.
  - Default parameter constants.
  - Helper function sat_sub(a,b) for the clamped subtraction.
- One natural sub-module, droop_baseline_tracker. It owns the calibration sum, the IIR accumulator and the baseline output, with cal_en, track_en and freeze controls from the FSM.
- The FSM, counters and brake register stay in droop_detector.

Test Plan:
- Calibration: enable=1, 16 valid samples of 500 -> ARMED after the 16th sample, baseline=500, brake=0, droop_events=0.
- Slow trip: from baseline 500, codes 480,470,470,470 -> 480 causes no count (480 is not below trip_th=476). The third 470 trips; brake=1 the following cycle, droop_events=1, droop_seen=1.
- Fast trip and hold: baseline 500, one sample of 430 (below fast_th=436) -> brake=1 next cycle. Then codes of 500 every cycle -> brake stays 1 for exactly MIN_HOLD=64 cycles, then drops.
- Hysteresis: in TRIPPED with the hold expired, alternate 15 samples of 495 with one of 490 (below rel_th=492) -> no release. Then 16 consecutive samples of 495 -> brake=0, state ARMED.
- Tracking and non-qualification: in ARMED, ramp codes 500->560 by 1 per sample -> baseline follows within the 64-sample time constant and never trips. A code of 480 with sense_valid=0 -> ignored.
- Disable and sticky: mid-TRIPPED drive enable=0 -> brake=0 next cycle, state IDLE, droop_events retained. clear_seen=1 -> droop_seen=0. Assert resetn=0 -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/droop_pkg.sv
// droop_pkg: shared state type, default parameters and clamped-subtract helper for the droop detector
package droop_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAL     = 2'd1,
        ARMED   = 2'd2,
        TRIPPED = 2'd3
    } droop_det_state_t;
    localparam int W_DEF             = 10;
    localparam int CAL_LOG2_DEF      = 4;
    localparam int TRACK_SHIFT_DEF   = 6;
    localparam int TRIP_DELTA_DEF    = 24;
    localparam int TRIP_COUNT_DEF    = 3;
    localparam int FAST_DELTA_DEF    = 64;
    localparam int RELEASE_DELTA_DEF = 8;
    localparam int RELEASE_COUNT_DEF = 16;
    localparam int MIN_HOLD_DEF      = 64;
    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a - b : 32'd0;
    endfunction
endpackage

// File: rtl/droop_baseline_tracker.sv
// droop_baseline_tracker: calibration averager and IIR drift tracker producing the baseline code
//   refclk, resetn : clock, async active-low reset
//   cal_clr        : restart calibration (sum and count to 0)
//   cal_en         : valid calibration sample this cycle
//   track_en       : valid sample while armed
//   freeze         : hold the baseline (sample below trip threshold)
//   code           : sensor code
//   cal_done       : this calibration sample completes the average
//   baseline       : current baseline code
module droop_baseline_tracker
    import droop_pkg::*;
#(
    parameter int W           = W_DEF,
    parameter int CAL_LOG2    = CAL_LOG2_DEF,
    parameter int TRACK_SHIFT = TRACK_SHIFT_DEF
) (
    input  logic         refclk,
    input  logic         resetn,
    input  logic         cal_clr,
    input  logic         cal_en,
    input  logic         track_en,
    input  logic         freeze,
    input  logic [W-1:0] code,
    output logic         cal_done,
    output logic [W-1:0] baseline
);
    logic [W+CAL_LOG2-1:0]    cal_sum, cal_sum_nxt;
    logic [CAL_LOG2-1:0]      cal_cnt;
    logic [W+TRACK_SHIFT-1:0] acc, acc_nxt;
    logic [W-1:0]             cal_avg;
    assign cal_sum_nxt = cal_sum + (W+CAL_LOG2)'(code);
    assign cal_done    = cal_en && (cal_cnt == '1);
    assign cal_avg     = W'(cal_sum_nxt >> CAL_LOG2);
    // acc holds baseline scaled by 2^TRACK_SHIFT; modular wrap of the intermediate sum is harmless
    assign acc_nxt     = acc + (W+TRACK_SHIFT)'(code) - (acc >> TRACK_SHIFT);
    always_ff @(posedge refclk or negedge resetn) begin
        if (!resetn) begin
            cal_sum  <= '0;
            cal_cnt  <= '0;
            acc      <= '0;
            baseline <= '0;
        end else begin
            if (cal_clr) begin
                cal_sum <= '0;
                cal_cnt <= '0;
            end else if (cal_en) begin
                cal_sum <= cal_done ? '0 : cal_sum_nxt;
                cal_cnt <= cal_cnt + CAL_LOG2'(1);
            end
            if (cal_done) begin
                baseline <= cal_avg;
                acc      <= {cal_avg, {TRACK_SHIFT{1'b0}}};
            end else if (track_en && !freeze) begin
                acc      <= acc_nxt;
                baseline <= W'(acc_nxt >> TRACK_SHIFT);
            end
        end
    end
endmodule

// File: rtl/droop_detector.sv
// droop_detector: learns a supply baseline and raises brake on a qualified fast drop below it
//   refclk, resetn : clock, async active-low reset
//   enable         : detector enable (low forces IDLE and brake=0)
//   sense_valid    : sense_code valid this cycle
//   sense_code     : supply-monitor code, higher = higher VDD
//   clear_seen     : clear sticky droop_seen
//   brake          : registered droop request
//   det_state      : current FSM state
//   baseline       : current baseline code
//   droop_events   : saturating trip count
//   droop_seen     : sticky trip flag
module droop_detector
    import droop_pkg::*;
#(
    parameter int W             = W_DEF,
    parameter int CAL_LOG2      = CAL_LOG2_DEF,
    parameter int TRACK_SHIFT   = TRACK_SHIFT_DEF,
    parameter int TRIP_DELTA    = TRIP_DELTA_DEF,
    parameter int TRIP_COUNT    = TRIP_COUNT_DEF,
    parameter int FAST_DELTA    = FAST_DELTA_DEF,
    parameter int RELEASE_DELTA = RELEASE_DELTA_DEF,
    parameter int RELEASE_COUNT = RELEASE_COUNT_DEF,
    parameter int MIN_HOLD      = MIN_HOLD_DEF
) (
    input  logic         refclk,
    input  logic         resetn,
    input  logic         enable,
    input  logic         sense_valid,
    input  logic [W-1:0] sense_code,
    input  logic         clear_seen,
    output logic         brake,
    output logic [1:0]   det_state,
    output logic [W-1:0] baseline,
    output logic [15:0]  droop_events,
    output logic         droop_seen
);
    localparam int SW = $clog2(TRIP_COUNT + 1);
    localparam int HW = $clog2(MIN_HOLD + 1);
    localparam int RW = $clog2(RELEASE_COUNT + 1);
    droop_det_state_t state, state_nxt;
    logic [W-1:0]  trip_th, fast_th, rel_th;
    logic [SW-1:0] slow_cnt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [RW-1:0] rel_cnt, rel_nxt;
    logic          vs, below_trip, below_fast, below_rel, trip, rel_ok, cal_clr, cal_done;
    assign trip_th    = W'(sat_sub(32'(baseline), 32'(TRIP_DELTA)));
    assign fast_th    = W'(sat_sub(32'(baseline), 32'(FAST_DELTA)));
    assign rel_th     = W'(sat_sub(32'(baseline), 32'(RELEASE_DELTA)));
    assign vs         = enable && sense_valid;
    assign below_trip = sense_code < trip_th;
    assign below_fast = sense_code < fast_th;
    assign below_rel  = sense_code < rel_th;
    assign trip       = (state == ARMED) && vs && (below_fast || (below_trip && slow_cnt == SW'(TRIP_COUNT - 1)));
    assign hold_nxt   = (hold_cnt != '0) ? hold_cnt - HW'(1) : '0;
    assign rel_nxt    = !vs ? rel_cnt : below_rel ? '0 : (rel_cnt == RW'(RELEASE_COUNT)) ? rel_cnt : rel_cnt + RW'(1);
    // release is judged on this cycle's updated counters so brake drops on the edge the hold completes
    assign rel_ok     = (state == TRIPPED) && (hold_nxt == '0) && (rel_nxt >= RW'(RELEASE_COUNT));
    assign det_state  = state;
    always_comb begin
        state_nxt = state;
        cal_clr   = 1'b0;
        if (!enable) state_nxt = IDLE;
        else begin
            case (state)
                IDLE:    begin state_nxt = CAL; cal_clr = 1'b1; end
                CAL:     state_nxt = cal_done ? ARMED : CAL;
                ARMED:   state_nxt = trip ? TRIPPED : ARMED;
                TRIPPED: state_nxt = rel_ok ? ARMED : TRIPPED;
                default: state_nxt = IDLE;
            endcase
        end
    end
    always_ff @(posedge refclk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge refclk or negedge resetn) begin
        if (!resetn) begin
            brake        <= 1'b0;
            slow_cnt     <= '0;
            hold_cnt     <= '0;
            rel_cnt      <= '0;
            droop_events <= '0;
            droop_seen   <= 1'b0;
        end else begin
            brake        <= (state_nxt == TRIPPED);
            slow_cnt     <= (state != ARMED || trip) ? '0 : !vs ? slow_cnt : below_trip ? slow_cnt + SW'(1) : '0;
            hold_cnt     <= trip ? HW'(MIN_HOLD) : (state == TRIPPED) ? hold_nxt : hold_cnt;
            rel_cnt      <= trip ? '0 : (state == TRIPPED) ? rel_nxt : rel_cnt;
            droop_events <= (trip && droop_events != 16'hFFFF) ? droop_events + 16'd1 : droop_events;
            droop_seen   <= trip ? 1'b1 : clear_seen ? 1'b0 : droop_seen;
        end
    end
    droop_baseline_tracker #(
        .W(W),
        .CAL_LOG2(CAL_LOG2),
        .TRACK_SHIFT(TRACK_SHIFT)
    ) u_tracker (
        .refclk(refclk),
        .resetn(resetn),
        .cal_clr(cal_clr),
        .cal_en((state == CAL) && vs),
        .track_en((state == ARMED) && vs),
        .freeze(below_trip),
        .code(sense_code),
        .cal_done(cal_done),
        .baseline(baseline)
    );
endmodule

// File: tb/tb_droop_detector.sv
// tb_droop_detector: vector table, hand sequences and randomized run against a reference model
module tb_droop_detector;
    localparam int S_IDLE = 0, S_CAL = 1, S_ARMED = 2, S_TRIP = 3;
    logic        refclk = 1'b0, resetn = 1'b0, enable = 1'b0, sense_valid = 1'b0, clear_seen = 1'b0;
    logic [9:0]  sense_code = '0;
    logic        brake, droop_seen;
    logic [1:0]  det_state;
    logic [9:0]  baseline;
    logic [15:0] droop_events;
    int n_chk = 0, n_fail = 0;
    int m_state, m_base, m_acc, m_sum, m_n, m_slow, m_hold, m_rel, m_ev;
    bit m_seen;
    typedef struct {
        bit en; bit v; int code; bit clr;
        bit eb; int es; int ebase; int eev; bit eseen;
    } vec_t;
    vec_t tbl[$];
    droop_detector dut (
        .refclk(refclk), .resetn(resetn), .enable(enable), .sense_valid(sense_valid),
        .sense_code(sense_code), .clear_seen(clear_seen), .brake(brake), .det_state(det_state),
        .baseline(baseline), .droop_events(droop_events), .droop_seen(droop_seen)
    );
    always #5 refclk = ~refclk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    function automatic int sat(input int a, input int b);
        return a > b ? a - b : 0;
    endfunction
    task automatic model_reset();
        m_state = S_IDLE; m_base = 0; m_acc = 0; m_sum = 0; m_n = 0;
        m_slow = 0; m_hold = 0; m_rel = 0; m_ev = 0; m_seen = 0;
    endtask
    task automatic model_step(input bit en, input bit v, input int code, input bit clr);
        bit trip = 0;
        int tt, ft, rt;
        tt = sat(m_base, 24); ft = sat(m_base, 64); rt = sat(m_base, 8);
        if (!en) m_state = S_IDLE;
        else case (m_state)
            S_IDLE: begin m_state = S_CAL; m_sum = 0; m_n = 0; end
            S_CAL: if (v) begin
                m_sum += code; m_n++;
                if (m_n == 16) begin
                    m_base = m_sum / 16; m_acc = m_base * 64; m_state = S_ARMED; m_slow = 0;
                end
            end
            S_ARMED: if (v) begin
                if (code < tt) m_slow++;
                else begin m_slow = 0; m_acc = m_acc + code - m_acc / 64; m_base = m_acc / 64; end
                trip = (code < ft) || (m_slow >= 3);
                if (trip) begin
                    m_state = S_TRIP; m_hold = 64; m_rel = 0; m_slow = 0;
                    if (m_ev < 65535) m_ev++;
                end
            end
            default: begin
                if (m_hold > 0) m_hold--;
                if (v) m_rel = (code >= rt) ? (m_rel < 16 ? m_rel + 1 : 16) : 0;
                if (m_hold == 0 && m_rel >= 16) begin m_state = S_ARMED; m_slow = 0; end
            end
        endcase
        if (trip) m_seen = 1;
        else if (clr) m_seen = 0;
    endtask
    task automatic step(input bit en, input bit v, input int code, input bit clr);
        enable = en; sense_valid = v; sense_code = 10'(code); clear_seen = clr;
        @(posedge refclk);
        model_step(en, v, code, clr);
        #1;
        chk("model brake", 32'(brake), 32'(m_state == S_TRIP));
        chk("model state", 32'(det_state), 32'(m_state));
        chk("model baseline", 32'(baseline), 32'(m_base));
        chk("model events", 32'(droop_events), 32'(m_ev));
        chk("model seen", 32'(droop_seen), 32'(m_seen));
    endtask
    task automatic hold_len(input int code, output int len);
        len = 1;
        for (int k = 0; k < 300 && brake; k++) begin
            step(1, 1, code, 0);
            if (brake) len++;
        end
    endtask
    task automatic calibrate(input int code);
        step(1, 0, 0, 0);
        repeat (16) step(1, 1, code, 0);
        chk("cal state", 32'(det_state), S_ARMED);
        chk("cal baseline", 32'(baseline), 32'(code));
    endtask
    initial begin
        int len, ev0;
        bit saw_brake;
        model_reset();
        tbl.push_back('{1, 0, 0, 0, 0, S_CAL, 0, 0, 0});
        for (int i = 0; i < 15; i++) tbl.push_back('{1, 1, 500, 0, 0, S_CAL, 0, 0, 0});
        tbl.push_back('{1, 1, 500, 0, 0, S_ARMED, 500, 0, 0});
        tbl.push_back('{1, 0, 300, 0, 0, S_ARMED, 500, 0, 0});
        tbl.push_back('{1, 1, 480, 0, 0, S_ARMED, 499, 0, 0});
        tbl.push_back('{1, 1, 470, 0, 0, S_ARMED, 499, 0, 0});
        tbl.push_back('{1, 1, 470, 0, 0, S_ARMED, 499, 0, 0});
        tbl.push_back('{1, 1, 470, 0, 1, S_TRIP, 499, 1, 1});
        repeat (2) @(posedge refclk);
        #1;
        chk("reset brake", 32'(brake), 0);
        chk("reset state", 32'(det_state), S_IDLE);
        chk("reset baseline", 32'(baseline), 0);
        chk("reset events", 32'(droop_events), 0);
        chk("reset seen", 32'(droop_seen), 0);
        @(negedge refclk) resetn = 1'b1;
        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].v, tbl[i].code, tbl[i].clr);
            chk($sformatf("tbl%0d brake", i), 32'(brake), 32'(tbl[i].eb));
            chk($sformatf("tbl%0d state", i), 32'(det_state), 32'(tbl[i].es));
            chk($sformatf("tbl%0d baseline", i), 32'(baseline), 32'(tbl[i].ebase));
            chk($sformatf("tbl%0d events", i), 32'(droop_events), 32'(tbl[i].eev));
            chk($sformatf("tbl%0d seen", i), 32'(droop_seen), 32'(tbl[i].eseen));
        end
        hold_len(500, len);
        chk("slow hold length", 32'(len), 64);
        chk("after hold state", 32'(det_state), S_ARMED);
        step(1, 1, 430, 0);
        chk("fast trip brake", 32'(brake), 1);
        chk("fast trip events", 32'(droop_events), 2);
        hold_len(500, len);
        chk("fast hold length", 32'(len), 64);
        step(1, 1, 400, 0);
        chk("hyst trip brake", 32'(brake), 1);
        repeat (70) step(1, 1, 490, 0);
        chk("hyst hold expired brake", 32'(brake), 1);
        for (int r = 0; r < 3; r++) begin
            repeat (15) step(1, 1, 495, 0);
            step(1, 1, 490, 0);
            chk("hyst alternate brake", 32'(brake), 1);
            chk("hyst alternate state", 32'(det_state), S_TRIP);
        end
        repeat (15) step(1, 1, 495, 0);
        chk("hyst 15 brake", 32'(brake), 1);
        step(1, 1, 495, 0);
        chk("hyst 16 brake", 32'(brake), 0);
        chk("hyst 16 state", 32'(det_state), S_ARMED);
        saw_brake = 0;
        for (int c = 500; c <= 560; c++) begin
            step(1, 1, c, 0);
            saw_brake |= brake;
        end
        chk("ramp no brake", 32'(saw_brake), 0);
        chk("ramp events", 32'(droop_events), 3);
        chk("ramp baseline rose", 32'(baseline > 10'd499 && baseline < 10'd561), 1);
        step(1, 0, 300, 0);
        chk("invalid ignored brake", 32'(brake), 0);
        for (int i = 0; i < 1500; i++) begin
            int c;
            c = m_base + int'($urandom_range(0, 140)) - 100;
            c = c < 0 ? 0 : (c > 1023 ? 1023 : c);
            step($urandom_range(0, 199) != 0, $urandom_range(0, 9) < 7, c, $urandom_range(0, 49) == 0);
        end
        step(0, 0, 0, 0);
        calibrate(500);
        step(1, 1, 400, 1);
        chk("trip with clear seen", 32'(droop_seen), 1);
        chk("trip with clear brake", 32'(brake), 1);
        ev0 = m_ev;
        step(0, 0, 0, 0);
        chk("disable brake", 32'(brake), 0);
        chk("disable state", 32'(det_state), S_IDLE);
        chk("disable events kept", 32'(droop_events), 32'(ev0));
        chk("disable seen kept", 32'(droop_seen), 1);
        step(0, 0, 0, 1);
        chk("clear seen", 32'(droop_seen), 0);
        calibrate(500);
        step(1, 1, 400, 0);
        chk("pre-reset brake", 32'(brake), 1);
        #2 resetn = 1'b0;
        #1;
        chk("async brake", 32'(brake), 0);
        chk("async state", 32'(det_state), S_IDLE);
        chk("async baseline", 32'(baseline), 0);
        chk("async events", 32'(droop_events), 0);
        chk("async seen", 32'(droop_seen), 0);
        model_reset();
        @(negedge refclk) resetn = 1'b1;
        step(0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
